wb_rd_ctrl: RTL and testbench

WB_RD_CTRL -- requirements
Module: wb_rd_ctrl

---
 rtl/wb_rd_ctrl_if.sv | 61 ++++++
 rtl/wb_rd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wb_rd_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rd_ctrl_if.sv
// Weight-buffer read controller bus bundle.
// Groups the job-request inputs (start/config/stall/abort) and the
// weight-buffer port-B read outputs of wb_rd_ctrl.
//   slave  : the controller side (job inputs in, read port out)
//   master : the job issuer / weight-buffer side
interface wb_rd_ctrl_if #(
  parameter int unsigned AWD    = 13,
  parameter int unsigned LEN_WD = 13,
  parameter int unsigned REP_WD = 8
) ();

  // Job request / flow control
  logic              i_start;
  logic [AWD-1:0]    i_base_addr;
  logic [LEN_WD-1:0] i_len;
  logic [REP_WD-1:0] i_repeat;
  logic              i_bypass;
  logic              i_stall;
  logic              i_abort;

  // Weight-buffer read port and job status
  logic [AWD-1:0]    o_wb_raddr;
  logic              o_wb_rd_en;
  logic              o_bypass_wb;
  logic              o_rd_last;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start,
    input  i_base_addr,
    input  i_len,
    input  i_repeat,
    input  i_bypass,
    input  i_stall,
    input  i_abort,
    output o_wb_raddr,
    output o_wb_rd_en,
    output o_bypass_wb,
    output o_rd_last,
    output o_busy,
    output o_done
  );

  modport master (
    output i_start,
    output i_base_addr,
    output i_len,
    output i_repeat,
    output i_bypass,
    output i_stall,
    output i_abort,
    input  o_wb_raddr,
    input  o_wb_rd_en,
    input  o_bypass_wb,
    input  o_rd_last,
    input  o_busy,
    input  o_done
  );

endinterface

// File: rtl/wb_rd_ctrl.sv
// Weight-buffer read controller.
// Walks a block of len rows starting at base, repeat+1 times, issuing one
// weight-buffer read per unstalled cycle. The final read carries o_rd_last
// and o_done; abort cancels a job without a done pulse.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : wb_rd_ctrl_if.slave
//            in : i_start, i_base_addr, i_len, i_repeat, i_bypass,
//                 i_stall, i_abort
//            out: o_wb_raddr, o_wb_rd_en, o_bypass_wb, o_rd_last,
//                 o_busy, o_done (all registered)
module wb_rd_ctrl #(
  parameter int unsigned AWD    = 13,
  parameter int unsigned LEN_WD = 13,
  parameter int unsigned REP_WD = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  wb_rd_ctrl_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;

  // Captured job configuration
  logic [AWD-1:0]    base_q, base_d;
  logic [LEN_WD-1:0] len_q, len_d;
  logic [REP_WD-1:0] rep_q, rep_d;
  logic              byp_q, byp_d;

  // Sequencing counters: row_cnt < len, pass_cnt <= repeat
  logic [AWD-1:0]    addr_q, addr_d;
  logic [LEN_WD-1:0] row_cnt_q, row_cnt_d;
  logic [REP_WD-1:0] pass_cnt_q, pass_cnt_d;

  // Output registers
  logic [AWD-1:0]    raddr_q, raddr_d;
  logic              rd_en_q, rd_en_d;
  logic              bypass_q, bypass_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              last_row_c;
  logic              last_pass_c;

  assign last_row_c  = (row_cnt_q == (len_q - LEN_WD'(1)));
  assign last_pass_c = (pass_cnt_q == rep_q);

  // Next-state, sequencing and output decode
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    rep_d      = rep_q;
    byp_d      = byp_q;
    addr_d     = addr_q;
    row_cnt_d  = row_cnt_q;
    pass_cnt_d = pass_cnt_q;
    raddr_d    = raddr_q;
    rd_en_d    = 1'b0;
    bypass_d   = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len == '0) begin
            // Empty job completes immediately without touching the buffer
            done_d = 1'b1;
          end else begin
            base_d     = bus.i_base_addr;
            len_d      = bus.i_len;
            rep_d      = bus.i_repeat;
            byp_d      = bus.i_bypass;
            addr_d     = bus.i_base_addr;
            row_cnt_d  = '0;
            pass_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (bus.i_abort) begin
          // Abort wins over stall and over a final issue
          state_d = ST_IDLE;
        end else if (!bus.i_stall) begin
          rd_en_d  = 1'b1;
          raddr_d  = addr_q;
          bypass_d = byp_q;
          if (!last_row_c) begin
            addr_d    = addr_q + AWD'(1);
            row_cnt_d = row_cnt_q + LEN_WD'(1);
          end else if (!last_pass_c) begin
            addr_d     = base_q;
            row_cnt_d  = '0;
            pass_cnt_d = pass_cnt_q + REP_WD'(1);
          end else begin
            last_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // State, configuration, counter and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      byp_q      <= 1'b0;
      addr_q     <= '0;
      row_cnt_q  <= '0;
      pass_cnt_q <= '0;
      raddr_q    <= '0;
      rd_en_q    <= 1'b0;
      bypass_q   <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      byp_q      <= byp_d;
      addr_q     <= addr_d;
      row_cnt_q  <= row_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      raddr_q    <= raddr_d;
      rd_en_q    <= rd_en_d;
      bypass_q   <= bypass_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_wb_raddr  = raddr_q;
  assign bus.o_wb_rd_en  = rd_en_q;
  assign bus.o_bypass_wb = bypass_q;
  assign bus.o_rd_last   = last_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_wb_rd_ctrl.sv
// Testbench for wb_rd_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based
// model of the job's read-address sequence.
module tb_wb_rd_ctrl;

  localparam int unsigned AWD    = 13;
  localparam int unsigned LEN_WD = 13;
  localparam int unsigned REP_WD = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  wb_rd_ctrl_if #(.AWD(AWD), .LEN_WD(LEN_WD), .REP_WD(REP_WD)) bus ();

  wb_rd_ctrl #(.AWD(AWD), .LEN_WD(LEN_WD), .REP_WD(REP_WD)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A job is the flat list of addresses it must read; each unstalled RUN
  // cycle pops one, and the pop that empties the list is the final read.
  logic [AWD-1:0] q_addr[$];
  bit             m_active = 1'b0;
  bit             m_byp    = 1'b0;
  logic [AWD-1:0] e_raddr  = '0;
  bit e_rd_en = 1'b0, e_byp = 1'b0, e_last = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_addr.delete();
      m_active = 1'b0; m_byp = 1'b0;
      e_raddr = '0; e_rd_en = 1'b0; e_byp = 1'b0;
      e_last = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_rd_en = 1'b0; e_byp = 1'b0; e_last = 1'b0; e_done = 1'b0;
      if (!m_active) begin
        if (bus.i_start) begin
          if (bus.i_len == '0) e_done = 1'b1;
          else begin
            q_addr.delete();
            for (int p = 0; p <= int'(bus.i_repeat); p++)
              for (int r = 0; r < int'(bus.i_len); r++)
                q_addr.push_back(AWD'(int'(bus.i_base_addr) + r));
            m_active = 1'b1;
            m_byp    = bus.i_bypass;
          end
        end
      end else if (bus.i_abort) begin
        m_active = 1'b0;
        q_addr.delete();
      end else if (!bus.i_stall) begin
        e_raddr = q_addr.pop_front();
        e_rd_en = 1'b1;
        e_byp   = m_byp;
        if (q_addr.size() == 0) begin
          e_last = 1'b1; e_done = 1'b1; m_active = 1'b0;
        end
      end
      e_busy = m_active;
    end
  end

  // ---------------- per-cycle compare + activity log ----------------
  int log_addr[$];
  int log_cyc[$];
  int log_done = 0, log_last = 0, log_byp = 0;
  int done_cyc = 0, done_addr = 0;

  always @(negedge i_clk) begin
    chk("raddr",  bus.o_wb_raddr,  e_raddr);
    chk("rd_en",  bus.o_wb_rd_en,  e_rd_en);
    chk("bypass", bus.o_bypass_wb, e_byp);
    chk("last",   bus.o_rd_last,   e_last);
    chk("busy",   bus.o_busy,      e_busy);
    chk("done",   bus.o_done,      e_done);
    if (bus.o_wb_rd_en) begin
      log_addr.push_back(int'(bus.o_wb_raddr));
      log_cyc.push_back(cyc);
      if (bus.o_bypass_wb) log_byp++;
    end
    if (bus.o_done) begin
      log_done++; done_cyc = cyc; done_addr = int'(bus.o_wb_raddr);
    end
    if (bus.o_rd_last) log_last++;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge i_clk); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_cyc.delete();
    log_done = 0; log_last = 0; log_byp = 0; done_cyc = 0; done_addr = 0;
  endtask

  task automatic start(input int base, input int len, input int rep, input bit byp);
    bus.i_start     = 1'b1;
    bus.i_base_addr = AWD'(base);
    bus.i_len       = LEN_WD'(len);
    bus.i_repeat    = REP_WD'(rep);
    bus.i_bypass    = byp;
  endtask

  // Drop start and scramble the config so a running job must use its capture
  task automatic release_start();
    bus.i_start     = 1'b0;
    bus.i_base_addr = AWD'($urandom);
    bus.i_len       = LEN_WD'($urandom_range(0, 9));
    bus.i_repeat    = REP_WD'($urandom_range(0, 3));
    bus.i_bypass    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!bus.o_busy && !m_active) return;
      tick();
    end
    n_total++;
    $display("FAIL wait_idle: o_busy=%0b still after %0d cycles", bus.o_busy, limit);
  endtask

  task automatic chk_list(input string name, input int e[$]);
    chk({name, "_count"}, log_addr.size(), e.size());
    for (int i = 0; i < e.size() && i < log_addr.size(); i++)
      chk(name, log_addr[i], e[i]);
  endtask

  task automatic chk_rel(input string name, input int s, input int e[$]);
    for (int i = 0; i < e.size() && i < log_cyc.size(); i++)
      chk(name, log_cyc[i] - s, e[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_raddr"},  bus.o_wb_raddr,  0);
    chk({tag, "_rd_en"},  bus.o_wb_rd_en,  0);
    chk({tag, "_bypass"}, bus.o_bypass_wb, 0);
    chk({tag, "_last"},   bus.o_rd_last,   0);
    chk({tag, "_busy"},   bus.o_busy,      0);
    chk({tag, "_done"},   bus.o_done,      0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int eq[$];

    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_len = '0;
    bus.i_repeat = '0; bus.i_bypass = 1'b0; bus.i_stall = 1'b0; bus.i_abort = 1'b0;

    repeat (3) tick();
    chk_all_zero("reset");

    // Basic job, started on the first edge after reset release
    clear_logs();
    i_rst = 1'b0;
    s = cyc; start(10, 4, 0, 0);
    tick(); release_start();
    wait_idle(50); tick();
    eq = '{10, 11, 12, 13};  chk_list("basic_addr", eq);
    eq = '{2, 3, 4, 5};      chk_rel("basic_cyc", s, eq);
    chk("basic_done_cnt", log_done, 1);
    chk("basic_last_cnt", log_last, 1);
    chk("basic_done_addr", done_addr, 13);
    chk("basic_done_cyc", done_cyc - s, 5);

    // Repeat job: three passes over 100..102
    clear_logs();
    s = cyc; start(100, 3, 2, 0);
    tick(); release_start();
    wait_idle(50); tick();
    eq = '{100, 101, 102, 100, 101, 102, 100, 101, 102};
    chk_list("repeat_addr", eq);
    chk("repeat_done_cnt", log_done, 1);
    chk("repeat_done_addr", done_addr, 102);
    chk("repeat_done_cyc", done_cyc - s, 10);

    // Stall after the 2nd issue, address wraps past 8191
    clear_logs();
    s = cyc; start(8190, 4, 0, 0);
    tick(); release_start();
    tick(); tick(); bus.i_stall = 1'b1;
    tick();
    chk("stall_rd_en", bus.o_wb_rd_en, 0);
    chk("stall_raddr_hold", bus.o_wb_raddr, 8191);
    tick(); bus.i_stall = 1'b0;
    wait_idle(50); tick();
    eq = '{8190, 8191, 0, 1};  chk_list("wrap_addr", eq);
    eq = '{2, 3, 6, 7};        chk_rel("wrap_cyc", s, eq);
    chk("wrap_done_cnt", log_done, 1);

    // Bypass job
    clear_logs();
    start(500, 2, 0, 1);
    tick(); release_start();
    wait_idle(50); tick();
    chk("bypass_reads", log_addr.size(), 2);
    chk("bypass_flags", log_byp, 2);
    chk("bypass_done_cnt", log_done, 1);

    // Empty job
    clear_logs();
    s = cyc; start(300, 0, 0, 0);
    tick(); release_start();
    tick(); tick();
    chk("empty_reads", log_addr.size(), 0);
    chk("empty_done_cnt", log_done, 1);
    chk("empty_done_cyc", done_cyc - s, 1);

    // Abort on the 3rd issue of a len=8 job
    clear_logs();
    start(20, 8, 0, 0);
    tick(); release_start();
    tick(); tick(); bus.i_abort = 1'b1;
    tick();
    chk("abort_rd_en", bus.o_wb_rd_en, 0);
    chk("abort_busy", bus.o_busy, 0);
    bus.i_abort = 1'b0;
    tick(); tick();
    chk("abort_reads", log_addr.size(), 2);
    chk("abort_done_cnt", log_done, 0);

    // Abort beats stall and a final issue in the same cycle
    clear_logs();
    start(40, 1, 0, 0);
    tick(); release_start(); bus.i_abort = 1'b1; bus.i_stall = 1'b1;
    tick(); bus.i_abort = 1'b0; bus.i_stall = 1'b0;
    tick(); tick();
    chk("abort_final_reads", log_addr.size(), 0);
    chk("abort_final_done", log_done, 0);

    // Abort in IDLE is ignored
    clear_logs();
    bus.i_abort = 1'b1; start(60, 2, 0, 0);
    tick(); release_start(); bus.i_abort = 1'b0;
    wait_idle(50); tick();
    eq = '{60, 61};  chk_list("idle_abort_addr", eq);

    // Reset mid-job, then restart
    clear_logs();
    start(200, 8, 0, 0);
    tick(); release_start();
    tick(); tick();
    #2 i_rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    tick(); tick();
    i_rst = 1'b0;
    clear_logs();
    start(7, 2, 0, 0);
    tick(); release_start();
    wait_idle(50); tick(); tick();
    eq = '{7, 8};  chk_list("post_reset_addr", eq);
    chk("post_reset_done_cnt", log_done, 1);

    // Back-to-back: start during RUN ignored, start in the done cycle taken
    clear_logs();
    s = cyc; start(30, 3, 0, 0);
    tick(); start(999, 5, 1, 1);
    tick(); tick(); tick();
    start(50, 1, 0, 0);
    tick(); release_start();
    wait_idle(50); tick();
    eq = '{30, 31, 32, 50};  chk_list("b2b_addr", eq);
    eq = '{2, 3, 4, 6};      chk_rel("b2b_cyc", s, eq);
    chk("b2b_done_cnt", log_done, 2);
    chk("b2b_done_addr", done_addr, 50);
    chk("b2b_bypass", log_byp, 0);

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 4000; k++) begin
      tick();
      bus.i_start     = ($urandom_range(0, 3) == 0);
      bus.i_base_addr = ($urandom_range(0, 3) == 0) ? AWD'((1 << AWD) - int'($urandom_range(1, 4)))
                                                    : AWD'($urandom);
      bus.i_len       = ($urandom_range(0, 9) == 0) ? LEN_WD'($urandom_range(7, 40))
                                                    : LEN_WD'($urandom_range(0, 6));
      bus.i_repeat    = REP_WD'($urandom_range(0, 2));
      bus.i_bypass    = 1'($urandom_range(0, 1));
      bus.i_stall     = ($urandom_range(0, 3) == 0);
      bus.i_abort     = ($urandom_range(0, 60) == 0);
      i_rst           = ($urandom_range(0, 500) == 0);
    end
    tick();
    i_rst = 1'b0; bus.i_start = 1'b0; bus.i_stall = 1'b0; bus.i_abort = 1'b0;
    wait_idle(1000); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
